// File: rtl/calc_cmd_ctrl_pkg.sv
// Shared types and constants for the calculator command controller.
// Holds the FSM states, ALU op codes and the ASCII bytes of the frame.
package calc_cmd_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SP1,
    MODE,
    SP2,
    OPA,
    OPR,
    OPB,
    EQ,
    EXEC,
    WAIT,
    TX_RES,
    TX_ERR
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_LS    = 8'h73;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_LU    = 8'h75;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/calc_hex_codec.sv
// ASCII hex digit to nibble decoder with valid flag, and
// nibble to uppercase ASCII hex encoder.
module calc_hex_codec (
  input  logic [7:0] asc_in,
  output logic [3:0] nib_out,
  output logic       nib_ok,
  input  logic [3:0] nib_in,
  output logic [7:0] asc_out
);

  always_comb begin
    nib_out = 4'h0;
    nib_ok  = 1'b0;
    unique case (1'b1)
      (asc_in >= 8'h30 && asc_in <= 8'h39): begin
        nib_out = asc_in[3:0];
        nib_ok  = 1'b1;
      end
      (asc_in >= 8'h41 && asc_in <= 8'h46),
      (asc_in >= 8'h61 && asc_in <= 8'h66): begin
        nib_out = asc_in[3:0] + 4'd9;
        nib_ok  = 1'b1;
      end
      default: ;
    endcase
  end

  assign asc_out = (nib_in < 4'd10)
                 ? {4'h3, nib_in}
                 : 8'h37 + {4'h0, nib_in};

endmodule

// File: rtl/calc_cmd_ctrl.sv
// UART command parser: decodes "I <mode> A op B=" frames, drives the
// ALU and returns the result as hex text, or "E" on a bad frame.
module calc_cmd_ctrl
  import calc_cmd_ctrl_pkg::*;
#(
  parameter int OPW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [OPW-1:0]   alu_a,
  output logic [OPW-1:0]   alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_signed,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [2*OPW-1:0] alu_result,
  output logic             busy
);

  localparam int ND  = OPW / 4;
  localparam int NCH = 2 * OPW / 4;
  localparam int CW  = $clog2(NCH + 3);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [OPW-1:0]   a_sh;
  logic [OPW-1:0]   b_sh;
  logic [1:0]       op_sh;
  logic             sgn_sh;
  logic [2*OPW-1:0] res;

  logic [3:0] nib;
  logic       nib_ok;
  logic [3:0] enc_nib;
  logic [7:0] enc_ch;
  logic       hit;
  logic       tx_acc;
  logic       last_dig;

  calc_hex_codec u_codec (
    .asc_in  (rx_data),
    .nib_out (nib),
    .nib_ok  (nib_ok),
    .nib_in  (enc_nib),
    .asc_out (enc_ch)
  );

  // First result digit comes straight from the ALU bus on capture.
  assign enc_nib  = (state == WAIT) ? alu_result[2*OPW-1 -: 4]
                                    : res[2*OPW-1 -: 4];
  assign tx_acc   = tx_valid && tx_ready;
  assign last_dig = (cnt == CW'(ND - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    hit = 1'b0;
    unique case (state)
      SP1, SP2: hit = (rx_data == CH_SP);
      MODE:     hit = (rx_data == CH_S) || (rx_data == CH_LS) ||
                      (rx_data == CH_U) || (rx_data == CH_LU);
      OPA, OPB: hit = nib_ok;
      OPR:      hit = (rx_data == CH_PLUS) || (rx_data == CH_MINUS) ||
                      (rx_data == CH_STAR);
      EQ:       hit = (rx_data == CH_EQ);
      default:  hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      op_sh      <= OP_ADD;
      sgn_sh     <= 1'b0;
      res        <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
      alu_signed <= 1'b0;
      alu_start  <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid && rx_data == CH_I) begin
            state <= SP1;
            cnt   <= '0;
          end
        end
        SP1, MODE, SP2, OPA, OPR, OPB, EQ: begin
          if (rx_valid) begin
            if (rx_data == CH_I) begin
              state <= SP1;
              cnt   <= '0;
            end else if (!hit) begin
              state    <= TX_ERR;
              cnt      <= '0;
              tx_data  <= CH_E;
              tx_valid <= 1'b1;
            end else begin
              unique case (state)
                SP1: state <= MODE;
                MODE: begin
                  sgn_sh <= (rx_data == CH_S) || (rx_data == CH_LS);
                  state  <= SP2;
                end
                SP2: begin
                  state <= OPA;
                  cnt   <= '0;
                end
                OPA: begin
                  a_sh <= {a_sh[OPW-5:0], nib};
                  cnt  <= last_dig ? '0 : cnt + CW'(1);
                  if (last_dig) state <= OPR;
                end
                OPR: begin
                  op_sh <= (rx_data == CH_PLUS)  ? OP_ADD :
                           (rx_data == CH_MINUS) ? OP_SUB : OP_MUL;
                  state <= OPB;
                end
                OPB: begin
                  b_sh <= {b_sh[OPW-5:0], nib};
                  cnt  <= last_dig ? '0 : cnt + CW'(1);
                  if (last_dig) state <= EQ;
                end
                default: begin
                  alu_a      <= a_sh;
                  alu_b      <= b_sh;
                  alu_op     <= op_sh;
                  alu_signed <= sgn_sh;
                  alu_start  <= 1'b1;
                  state      <= EXEC;
                end
              endcase
            end
          end
        end
        EXEC: state <= WAIT;
        WAIT: begin
          if (alu_done) begin
            res      <= alu_result << 4;
            tx_data  <= enc_ch;
            tx_valid <= 1'b1;
            cnt      <= '0;
            state    <= TX_RES;
          end
        end
        TX_RES: begin
          if (tx_acc) begin
            cnt <= cnt + CW'(1);
            if (cnt < CW'(NCH - 1)) begin
              tx_data <= enc_ch;
              res     <= res << 4;
            end else if (cnt == CW'(NCH - 1)) begin
              tx_data <= CH_CR;
            end else if (cnt == CW'(NCH)) begin
              tx_data <= CH_LF;
            end else begin
              tx_valid <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end
          end
        end
        TX_ERR: begin
          if (tx_acc) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(0)) begin
              tx_data <= CH_CR;
            end else if (cnt == CW'(1)) begin
              tx_data <= CH_LF;
            end else begin
              tx_valid <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_ctrl.sv
// Scoreboard bench for calc_cmd_ctrl: ALU responder, TX checker
// with optional backpressure, and frame-level stimulus.
module tb_calc_cmd_ctrl;

  localparam int OPW = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        sg;
    logic [31:0] r;
  } alu_exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_signed;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int exp_starts = 0;
  int stray_req = 0;
  int stray_seen = 0;
  bit alu_auto = 1;
  bit stall_mode = 0;

  alu_exp_t   aluq[$];
  logic [7:0] txq[$];

  calc_cmd_ctrl #(.OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_signed (alu_signed),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  function automatic logic [31:0] model(input logic [15:0] a,
    input logic [15:0] b, input logic [1:0] op, input logic sg);
    logic [31:0] xa, xb;
    xa = sg ? {{16{a[15]}}, a} : {16'h0, a};
    xb = sg ? {{16{b[15]}}, b} : {16'h0, b};
    case (op)
      2'b00:   return xa + xb;
      2'b01:   return xa - xb;
      default: return xa * xb;
    endcase
  endfunction

  task automatic push_calc(input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, input logic sg,
                           input bit push_tx);
    alu_exp_t e;
    e.a = a; e.b = b; e.op = op; e.sg = sg;
    e.r = model(a, b, op, sg);
    aluq.push_back(e);
    exp_starts++;
    if (push_tx) begin
      for (int i = 7; i >= 0; i--) txq.push_back(hexc(e.r[i*4 +: 4]));
      txq.push_back(8'h0D);
      txq.push_back(8'h0A);
    end
  endtask

  task automatic push_err();
    txq.push_back(8'h45);
    txq.push_back(8'h0D);
    txq.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || txq.size() != 0 || aluq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < budget), 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_alu_start"}, alu_start, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_signed"}, alu_signed, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ALU responder: checks operands on each start, answers after a delay
  initial begin
    alu_exp_t e;
    alu_done = 0;
    alu_result = 0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_seen) begin
        stray_seen++;
        @(posedge clk); #1;
        alu_result = 32'h1234_5678;
        alu_done = 1;
        @(posedge clk); #1;
        alu_done = 0;
      end else if (!rst && alu_start) begin
        starts++;
        if (aluq.size() == 0) begin
          check("alu_unexpected", 64'(aluq.size()), 1);
        end else begin
          e = aluq.pop_front();
          check("alu_a", alu_a, e.a);
          check("alu_b", alu_b, e.b);
          check("alu_op", alu_op, e.op);
          check("alu_signed", alu_signed, e.sg);
          @(negedge clk);
          check("alu_start_pulse", alu_start, 0);
          if (alu_auto) begin
            repeat (2) @(posedge clk);
            #1;
            check("alu_a_hold", alu_a, e.a);
            alu_result = e.r;
            alu_done = 1;
            @(posedge clk); #1;
            alu_done = 0;
          end
        end
      end
    end
  end

  // Transmitter: accepts at once, or after 5 low cycles per char
  initial begin
    int w = 0;
    tx_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode) begin
        tx_ready = 1;
        w = 0;
      end else if (tx_valid) begin
        if (w < 5) begin
          tx_ready = 0;
          w++;
        end else begin
          tx_ready = 1;
          w = 0;
        end
      end else begin
        tx_ready = 0;
        w = 0;
      end
    end
  end

  // TX checker: in-order characters, stable data while stalled
  initial begin
    bit prev_stall = 0;
    logic [7:0] prev_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("tx_hold", tx_valid, 1);
          check("tx_stable", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (txq.size() == 0) check("tx_unexpected", 64'(txq.size()), 1);
          else check("tx_char", tx_data, txq.pop_front());
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  initial begin
    int n;
    rst = 1;
    rx_data = 0;
    rx_valid = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    @(posedge clk); #1;
    rst = 0;

    push_calc(16'hFFF5, 16'h0004, 2'b00, 1, 1);
    send_str("I S fff5+0004=");
    wait_idle("idle_add_s", 500);

    push_calc(16'hFFF3, 16'h0004, 2'b01, 0, 1);
    send_str("I U fff3-0004=");
    wait_idle("idle_sub_u", 500);

    push_calc(16'h0010, 16'h00A0, 2'b10, 1, 1);
    send_str("I s 0010*00A0=");
    wait_idle("idle_mul_s", 500);

    push_err();
    send_str("I S 12G");
    wait_idle("idle_err", 500);
    send_str("4");
    repeat (3) @(negedge clk);
    check("err_then_idle", busy, 0);

    push_calc(16'h0001, 16'h0002, 2'b00, 0, 1);
    send_str("I S 12I u 0001+0002=");
    wait_idle("idle_restart", 500);

    stall_mode = 1;
    push_calc(16'h0000, 16'h0001, 2'b01, 0, 1);
    send_str("I u 0000-0001=");
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", 64'(n < 100), 1);
    send_str("I U 1111+1111=");
    wait_idle("idle_stall", 2000);
    stall_mode = 0;

    alu_auto = 0;
    push_calc(16'h0002, 16'h0003, 2'b00, 1, 0);
    send_str("I S 0002+0003=");
    repeat (6) @(negedge clk);
    check("wait_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    reset_checks("wait_rst");
    @(posedge clk); #1;
    rst = 0;
    alu_auto = 1;
    stray_req++;
    repeat (6) @(negedge clk);
    check("stray_done_busy", busy, 0);
    check("stray_done_tx", tx_valid, 0);

    push_calc(16'hFFFF, 16'hFFFF, 2'b10, 0, 1);
    send_str("I U FFFF*ffff=");
    wait_idle("idle_final", 500);

    repeat (5) @(negedge clk);
    check("alu_start_count", 64'(starts), 64'(exp_starts));
    check("txq_empty", 64'(txq.size()), 0);
    check("aluq_empty", 64'(aluq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
